// File: rtl/multicycle_sequencer.sv
// Multi-cycle control FSM for the RV32I core: sequences FETCH/DECODE/EXEC/MEM/WB,
// gates decoder enables into one-cycle pulses and traps hung memory handshakes.
module multicycle_sequencer #(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned RETIRE_W    = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run,
    input  logic [6:0]          opcode,
    input  logic                mem_read_d,
    input  logic                mem_write_d,
    input  logic                reg_write_d,
    input  logic                imem_ready,
    input  logic                dmem_ready,
    input  logic                io_done,
    output logic                imem_req,
    output logic                ir_we,
    output logic                dmem_req,
    output logic                dmem_we,
    output logic                io_req,
    output logic                rf_we,
    output logic                pc_we,
    output logic                fault,
    output logic [2:0]          state,
    output logic [RETIRE_W-1:0] retired
);

    localparam int unsigned CNT_W    = $clog2(MEM_TIMEOUT + 1);
    localparam logic [6:0]  OP_ECALL = 7'b1110011;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_ECALL  = 3'd6,
        ST_FAULT  = 3'd7
    } state_e;

    state_e              state_q, state_d;
    logic [CNT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [RETIRE_W-1:0] retired_q, retired_d;
    logic                timed_out;

    assign state     = state_q;
    assign retired   = retired_q;
    assign timed_out = (wait_cnt_q == CNT_W'(MEM_TIMEOUT));

    // State register and counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            retired_q  <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            retired_q  <= retired_d;
        end
    end

    // Next-state logic; a retiring instruction (pc_we) overrides the per-state choice
    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        retired_d  = retired_q + RETIRE_W'(pc_we);
        unique case (state_q)
            ST_IDLE: begin
                if (run) begin
                    state_d    = ST_FETCH;
                    wait_cnt_d = '0;
                end
            end
            ST_FETCH: begin
                if (imem_ready)     state_d = ST_DECODE;
                else if (timed_out) state_d = ST_FAULT;
                else                wait_cnt_d = wait_cnt_q + CNT_W'(1);
            end
            ST_DECODE: state_d = ST_EXEC;
            ST_EXEC: begin
                if (opcode == OP_ECALL) begin
                    state_d = ST_ECALL;
                end else if (mem_read_d || mem_write_d) begin
                    state_d    = ST_MEM;
                    wait_cnt_d = '0;
                end else begin
                    state_d = ST_WB;
                end
            end
            ST_MEM: begin
                if (dmem_ready) begin
                    if (mem_read_d) state_d = ST_WB;
                end else if (timed_out) begin
                    state_d = ST_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_WB:    state_d = state_q;
            ST_ECALL: state_d = state_q;
            ST_FAULT: state_d = ST_FAULT;
            default:  state_d = ST_FAULT;
        endcase
        if (pc_we) begin
            state_d    = run ? ST_FETCH : ST_IDLE;
            wait_cnt_d = '0;
        end
    end

    // Output decode from state plus the handshake inputs
    always_comb begin
        imem_req = 1'b0;
        ir_we    = 1'b0;
        dmem_req = 1'b0;
        dmem_we  = 1'b0;
        io_req   = 1'b0;
        rf_we    = 1'b0;
        pc_we    = 1'b0;
        fault    = 1'b0;
        unique case (state_q)
            ST_FETCH: begin
                imem_req = 1'b1;
                ir_we    = imem_ready;
            end
            ST_MEM: begin
                dmem_req = 1'b1;
                dmem_we  = mem_write_d;
                pc_we    = dmem_ready && !mem_read_d;
            end
            ST_WB: begin
                rf_we = reg_write_d;
                pc_we = 1'b1;
            end
            ST_ECALL: begin
                io_req = 1'b1;
                rf_we  = io_done && reg_write_d;
                pc_we  = io_done;
            end
            ST_FAULT: fault = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Randomized bench for multicycle_sequencer: an instruction-level model expands each
// instruction into its expected cycle trace, which is replayed and compared per cycle.
module tb_multicycle_sequencer;

    localparam int unsigned TMO = 4;
    localparam int unsigned RW  = 4;

    localparam logic [7:0] O_FLT  = 8'h80;
    localparam logic [7:0] O_IREQ = 8'h40;
    localparam logic [7:0] O_IRWE = 8'h20;
    localparam logic [7:0] O_DREQ = 8'h10;
    localparam logic [7:0] O_DWE  = 8'h08;
    localparam logic [7:0] O_IO   = 8'h04;
    localparam logic [7:0] O_RF   = 8'h02;
    localparam logic [7:0] O_PC   = 8'h01;

    typedef struct packed {
        logic [2:0] st;
        logic [7:0] outs;
        logic       run;
        logic       ir;
        logic       dr;
        logic       io;
    } cyc_t;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic [6:0]    opcode;
    logic          mem_read_d, mem_write_d, reg_write_d;
    logic          imem_ready, dmem_ready, io_done;
    logic          imem_req, ir_we, dmem_req, dmem_we, io_req, rf_we, pc_we, fault;
    logic [2:0]    state;
    logic [RW-1:0] retired;
    logic [7:0]    obs_outs;

    cyc_t       q[$];
    logic [6:0] n_opc;
    logic       n_mr, n_mw, n_rw;
    bit         faulted;
    bit         parked;
    int         exp_ret;
    int         n_cmp = 0;
    int         n_err = 0;

    assign obs_outs = {fault, imem_req, ir_we, dmem_req, dmem_we, io_req, rf_we, pc_we};

    always #5 clk = ~clk;

    multicycle_sequencer #(.MEM_TIMEOUT(TMO), .RETIRE_W(RW)) dut (
        .clk(clk), .rst(rst), .run(run), .opcode(opcode),
        .mem_read_d(mem_read_d), .mem_write_d(mem_write_d), .reg_write_d(reg_write_d),
        .imem_ready(imem_ready), .dmem_ready(dmem_ready), .io_done(io_done),
        .imem_req(imem_req), .ir_we(ir_we), .dmem_req(dmem_req), .dmem_we(dmem_we),
        .io_req(io_req), .rf_we(rf_we), .pc_we(pc_we), .fault(fault),
        .state(state), .retired(retired)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic void push(input logic [2:0] st, input logic [7:0] outs,
                                 input logic r, input logic ir, input logic dr, input logic io);
        cyc_t c;
        c.st = st; c.outs = outs; c.run = r; c.ir = ir; c.dr = dr; c.io = io;
        q.push_back(c);
    endfunction

    function automatic void fault_tail();
        faulted = 1'b1;
        for (int k = 0; k < 3; k++) push(3'd7, O_FLT, rb(), rb(), rb(), rb());
    endfunction

    // Expand one instruction into its expected cycle trace
    function automatic void build(input int kind, input int fwait, input int dwait,
                                  input bit run_next, input bit from_idle);
        logic [7:0] wbv;
        q.delete();
        faulted = 1'b0;
        case (kind)
            0: begin n_opc = 7'b0110011; n_mr = 0; n_mw = 0; n_rw = rb(); end
            1: begin n_opc = 7'b0000011; n_mr = 1; n_mw = 0; n_rw = 1;    end
            2: begin n_opc = 7'b0100011; n_mr = 0; n_mw = 1; n_rw = 0;    end
            3: begin n_opc = 7'b1110011; n_mr = 0; n_mw = 0; n_rw = rb(); end
            4: begin n_opc = 7'b1100011; n_mr = 0; n_mw = 0; n_rw = 0;    end
            default: begin n_opc = 7'b0110111; n_mr = 0; n_mw = 0; n_rw = 1; end
        endcase
        wbv = n_rw ? (O_RF | O_PC) : O_PC;
        if (from_idle) push(3'd0, 8'h00, 1'b1, rb(), rb(), rb());
        for (int i = 0; i <= 2000; i++) begin
            if (i >= fwait) begin
                push(3'd1, O_IREQ | O_IRWE, rb(), 1'b1, rb(), rb());
                break;
            end
            push(3'd1, O_IREQ, rb(), 1'b0, rb(), rb());
            if (i == int'(TMO)) begin fault_tail(); return; end
        end
        push(3'd2, 8'h00, rb(), rb(), rb(), rb());
        push(3'd3, 8'h00, rb(), rb(), rb(), rb());
        if (kind == 3) begin
            for (int i = 0; i <= dwait; i++) begin
                if (i == dwait) push(3'd6, O_IO | wbv, run_next, rb(), rb(), 1'b1);
                else            push(3'd6, O_IO, rb(), rb(), rb(), 1'b0);
            end
        end else if (n_mr || n_mw) begin
            for (int i = 0; i <= 2000; i++) begin
                if (i >= dwait) begin
                    push(3'd4, O_DREQ | (n_mw ? O_DWE : 8'h00) | (n_mr ? 8'h00 : O_PC),
                         n_mr ? rb() : run_next, rb(), 1'b1, rb());
                    break;
                end
                push(3'd4, O_DREQ | (n_mw ? O_DWE : 8'h00), rb(), rb(), 1'b0, rb());
                if (i == int'(TMO)) begin fault_tail(); return; end
            end
            if (n_mr) push(3'd5, wbv, run_next, rb(), rb(), rb());
        end else begin
            push(3'd5, wbv, run_next, rb(), rb(), rb());
        end
    endfunction

    // Replay up to n cycles of the trace, checking state/outputs/retired each cycle
    task automatic run_q(input int n);
        int lim;
        lim = (n < q.size()) ? n : q.size();
        for (int i = 0; i < lim; i++) begin
            @(negedge clk);
            opcode      = n_opc;
            mem_read_d  = n_mr;
            mem_write_d = n_mw;
            reg_write_d = n_rw;
            run         = q[i].run;
            imem_ready  = q[i].ir;
            dmem_ready  = q[i].dr;
            io_done     = q[i].io;
            #1;
            check_eq("state", 32'(state), 32'(q[i].st));
            check_eq("outputs", 32'(obs_outs), 32'(q[i].outs));
            check_eq("retired", 32'(retired), 32'(exp_ret));
            if ((q[i].outs & O_PC) != 8'h00) exp_ret = (exp_ret + 1) % (1 << RW);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        run = rb();
        #1;
        exp_ret = 0;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_outputs", 32'(obs_outs), 32'd0);
        check_eq("rst_retired", 32'(retired), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        parked = 1'b1;
    endtask

    task automatic instr(input int kind, input int fwait, input int dwait, input bit run_next);
        build(kind, fwait, dwait, run_next, parked);
        run_q(q.size());
        if (faulted) do_reset();
        else         parked = !run_next;
    endtask

    initial begin
        rst = 1'b1; run = 1'b0; opcode = '0;
        mem_read_d = 0; mem_write_d = 0; reg_write_d = 0;
        imem_ready = 0; dmem_ready = 0; io_done = 0;
        n_opc = '0; n_mr = 0; n_mw = 0; n_rw = 0;
        exp_ret = 0; parked = 1'b1; faulted = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        check_eq("rst_state", 32'(state), 32'd0);
        check_eq("rst_outputs", 32'(obs_outs), 32'd0);
        check_eq("rst_retired", 32'(retired), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // run held low: stays parked in IDLE
        q.delete();
        for (int k = 0; k < 3; k++) push(3'd0, 8'h00, 1'b0, rb(), rb(), rb());
        run_q(q.size());

        instr(0, 0, 0, 1'b1);      // R-type, zero wait
        instr(1, 0, 3, 1'b1);      // load, 3 wait cycles in MEM
        instr(2, 0, 0, 1'b1);      // store
        instr(3, 0, 1000, 1'b0);   // ECALL with a long I/O wait: no timeout
        instr(0, int'(TMO), 0, 1'b0);      // imem ready exactly on the limit cycle
        instr(0, int'(TMO) + 1, 0, 1'b1);  // imem hung -> FAULT
        instr(2, 0, int'(TMO) + 1, 1'b1);  // dmem hung -> FAULT
        instr(1, 1, int'(TMO), 1'b0);      // dmem ready on the limit cycle

        // reset in the middle of a load's MEM wait
        build(1, 0, 3, 1'b1, parked);
        run_q(5);
        do_reset();

        for (int n = 0; n < 40; n++) begin
            int kind;
            kind = int'($urandom_range(0, 5));
            instr(kind, int'($urandom_range(0, TMO)),
                  (kind == 3) ? int'($urandom_range(0, 20)) : int'($urandom_range(0, TMO)),
                  ($urandom_range(0, 3) != 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
